// File: rtl/topo_pkg.sv
`default_nettype none
// topo_pkg -- shared mesh-link constants and packet field widths. Rev 1.0
package topo_pkg;

   localparam int LINK_MAX_DEPTH = 7;

   localparam int QOS_W  = 2;
   localparam int TYPE_W = 2;
   localparam int ID_W   = 4;
   localparam int FLIT_W = 28;

   // qos + type + src id + tgt id + data flit
   localparam int DEF_PYLD_W = QOS_W + TYPE_W + 2*ID_W + FLIT_W;

   function automatic int occ_width(input int depth);
      return (depth == 0) ? 1 : $clog2(2*depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/topo_link_stage.sv
`default_nettype none
// topo_link_stage -- two-entry elastic buffer with registered ready and flush. Rev 1.0
module topo_link_stage
   import topo_pkg::*;
#(
   parameter int W = DEF_PYLD_W
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         push, pop;

   // Ready depends only on the held count, so it never sees out_ready_i.
   assign in_ready_o  = ~cnt_q[1];
   assign out_valid_o = (cnt_q != 2'd0);
   assign out_data_o  = mem_q[rd_ptr_q];
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         cnt_q    <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data_i;
   end

endmodule
`default_nettype wire

// File: rtl/topo_link_pipe.sv
`default_nettype none
// topo_link_pipe -- DEPTH-stage elastic mesh link with enable, flush and drop counting. Rev 1.0
module topo_link_pipe
   import topo_pkg::*;
#(
   parameter  int PYLD_W = DEF_PYLD_W,
   parameter  int DEPTH  = 1,
   parameter  int CNT_W  = 8,
   localparam int OCC_W  = occ_width(DEPTH)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [PYLD_W-1:0] payload_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [PYLD_W-1:0] payload_o,
   input  logic              link_en,
   input  logic              flush,
   output logic [OCC_W-1:0]  occ,
   output logic              idle,
   output logic [CNT_W-1:0]  drop_cnt
);

   generate
      if (DEPTH == 0) begin : g_bypass
         logic pass;
         assign pass      = rst_n & link_en & ~flush;
         assign valid_o   = valid_i & pass;
         assign ready_o   = ready_i & pass;
         assign payload_o = payload_i;
         assign occ       = '0;
         assign idle      = 1'b1;
         assign drop_cnt  = '0;
      end else begin : g_pipe
         localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;
         localparam logic [CNT_W-1:0] CNT_MAX = '1;

         logic [DEPTH:0]    stg_valid;
         logic [DEPTH:0]    stg_ready;
         logic [PYLD_W-1:0] stg_data [DEPTH+1];
         logic              accept, deliver;
         logic [OCC_W-1:0]  occ_q, occ_d;
         logic [CNT_W-1:0]  drop_q, drop_d;
         logic [SUM_W-1:0]  drop_sum;

         assign ready_o          = rst_n & link_en & ~flush & stg_ready[0];
         assign stg_valid[0]     = valid_i & ready_o;
         assign stg_data[0]      = payload_i;
         // A flush cycle never completes an output transfer.
         assign stg_ready[DEPTH] = ready_i & ~flush;
         assign valid_o          = stg_valid[DEPTH];
         assign payload_o        = stg_data[DEPTH];

         for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            topo_link_stage #(.W(PYLD_W)) u_stage (
               .clk         (clk),
               .rst_n       (rst_n),
               .flush_i     (flush),
               .in_valid_i  (stg_valid[k]),
               .in_ready_o  (stg_ready[k]),
               .in_data_i   (stg_data[k]),
               .out_valid_o (stg_valid[k+1]),
               .out_ready_i (stg_ready[k+1]),
               .out_data_o  (stg_data[k+1])
            );
         end

         assign accept  = valid_i & ready_o;
         assign deliver = valid_o & stg_ready[DEPTH];

         always_comb begin
            occ_d    = occ_q;
            drop_d   = drop_q;
            drop_sum = SUM_W'(drop_q) + SUM_W'(occ_q);
            if (flush) begin
               occ_d  = '0;
               drop_d = (drop_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : drop_sum[CNT_W-1:0];
            end else begin
               occ_d  = occ_q + OCC_W'(accept) - OCC_W'(deliver);
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               occ_q  <= '0;
               drop_q <= '0;
            end else begin
               occ_q  <= occ_d;
               drop_q <= drop_d;
            end
         end

         assign occ      = occ_q;
         assign idle     = (occ_q == '0);
         assign drop_cnt = drop_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_topo_link_pipe.sv
`default_nettype none
// tb_topo_link_pipe -- queue-model scoreboard plus directed vectors over DEPTH 3/2/1/0 links.
module tb_topo_link_pipe;

   logic       clk = 1'b0;
   logic       rst_n, valid_i, ready_i, link_en, flush;
   logic [7:0] payload_i;

   logic       ro3, vo3, idle3;  logic [7:0] po3, drop3;  logic [2:0] occ3;
   logic       ro2, vo2, idle2;  logic [7:0] po2, drop2;  logic [2:0] occ2;
   logic       ro1, vo1, idle1;  logic [7:0] po1;         logic [1:0] drop1; logic [1:0] occ1;
   logic       ro0, vo0, idle0;  logic [7:0] po0, drop0;  logic [0:0] occ0;

   int n_vec = 0;
   int n_err = 0;
   int edge_n = 0;

   always #5 clk = ~clk;
   always @(posedge clk) edge_n++;

   topo_link_pipe #(.PYLD_W(8), .DEPTH(3), .CNT_W(8)) u_d3 (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ro3), .payload_i(payload_i),
      .valid_o(vo3), .ready_i(ready_i), .payload_o(po3), .link_en(link_en), .flush(flush),
      .occ(occ3), .idle(idle3), .drop_cnt(drop3));
   topo_link_pipe #(.PYLD_W(8), .DEPTH(2), .CNT_W(8)) u_d2 (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ro2), .payload_i(payload_i),
      .valid_o(vo2), .ready_i(ready_i), .payload_o(po2), .link_en(link_en), .flush(flush),
      .occ(occ2), .idle(idle2), .drop_cnt(drop2));
   topo_link_pipe #(.PYLD_W(8), .DEPTH(1), .CNT_W(2)) u_d1 (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ro1), .payload_i(payload_i),
      .valid_o(vo1), .ready_i(ready_i), .payload_o(po1), .link_en(link_en), .flush(flush),
      .occ(occ1), .idle(idle1), .drop_cnt(drop1));
   topo_link_pipe #(.PYLD_W(8), .DEPTH(0), .CNT_W(8)) u_d0 (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ro0), .payload_i(payload_i),
      .valid_o(vo0), .ready_i(ready_i), .payload_o(po0), .link_en(link_en), .flush(flush),
      .occ(occ0), .idle(idle0), .drop_cnt(drop0));

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction
   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic chk(input string nm, input int k, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s [inst %0d] t=%0t got 0x%0h expected 0x%0h", nm, k, $time, act, req);
      end
   endtask

   // Model: per-instance packet FIFO in acceptance order, with accept edge numbers.
   int         dep  [3] = '{3, 2, 1};
   int         cmax [3] = '{255, 255, 3};
   logic [7:0] mq   [3][16];
   int         macc [3][16];
   int         mh [3] = '{0, 0, 0};
   int         mt [3] = '{0, 0, 0};
   int         ms [3] = '{0, 0, 0};
   int         md [3] = '{0, 0, 0};

   always @(negedge clk) begin : p_cmp
      bit svo [3]; bit sro [3]; bit sidle [3];
      int spo [3]; int socc [3]; int sdrop [3];
      svo[0] = vo3;  svo[1] = vo2;  svo[2] = vo1;
      sro[0] = ro3;  sro[1] = ro2;  sro[2] = ro1;
      sidle[0] = idle3; sidle[1] = idle2; sidle[2] = idle1;
      spo[0] = int'(po3);  spo[1] = int'(po2);  spo[2] = int'(po1);
      socc[0] = int'(occ3); socc[1] = int'(occ2); socc[2] = int'(occ1);
      sdrop[0] = int'(drop3); sdrop[1] = int'(drop2); sdrop[2] = int'(drop1);
      for (int k = 0; k < 3; k++) begin
         chk("occ", k, socc[k], ms[k]);
         chk("idle", k, int'(sidle[k]), int'(ms[k] == 0));
         chk("drop_cnt", k, sdrop[k], md[k]);
         if (ms[k] == 0) chk("valid_when_empty", k, int'(svo[k]), 0);
         else if (edge_n + 1 < macc[k][mh[k]] + dep[k]) chk("valid_too_early", k, int'(svo[k]), 0);
         if (svo[k] && ms[k] > 0) chk("payload_order", k, spo[k], int'(mq[k][mh[k]]));
         if (!rst_n || !link_en || flush || ms[k] == 2*dep[k]) chk("ready_low", k, int'(sro[k]), 0);
         else if (ms[k] < 2) chk("ready_high", k, int'(sro[k]), 1);
         if (!rst_n) begin
            ms[k] = 0; mh[k] = 0; mt[k] = 0; md[k] = 0;
         end else if (flush) begin
            md[k] = imin(md[k] + ms[k], cmax[k]);
            ms[k] = 0; mh[k] = 0; mt[k] = 0;
         end else begin
            if (svo[k] && ready_i && ms[k] > 0) begin
               mh[k] = (mh[k] + 1) % 16; ms[k]--;
            end
            if (valid_i && sro[k]) begin
               mq[k][mt[k]] = payload_i; macc[k][mt[k]] = edge_n + 1;
               mt[k] = (mt[k] + 1) % 16; ms[k]++;
            end
         end
      end
      chk("d0_valid", 3, int'(vo0), int'(rst_n & valid_i & link_en & ~flush));
      chk("d0_ready", 3, int'(ro0), int'(rst_n & ready_i & link_en & ~flush));
      chk("d0_payload", 3, int'(po0), int'(payload_i));
      chk("d0_occ", 3, int'(occ0), 0);
      chk("d0_idle", 3, int'(idle0), 1);
      chk("d0_drop", 3, int'(drop0), 0);
   end

   task automatic drive(input bit v, input logic [7:0] p, input bit r,
                        input bit le, input bit fl, input bit rn);
      @(posedge clk); #1;
      valid_i = v; payload_i = p; ready_i = r; link_en = le; flush = fl; rst_n = rn;
      @(negedge clk);
   endtask

   task automatic fill(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) drive(1'b1, base + 8'(i), 1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic flush_and_clear();
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; valid_i = 1'b0; payload_i = 8'h00; ready_i = 1'b1; link_en = 1'b1; flush = 1'b0;
      drive(0, 8'h00, 1, 1, 0, 0);
      drive(0, 8'h00, 1, 1, 0, 0);
      chk("rst_ready", 0, int'(ro3), 0);
      chk("rst_idle", 0, int'(idle3), 1);
      drive(0, 8'h00, 1, 1, 0, 1);
      chk("post_rst_ready", 1, int'(ro2), 1);

      // Stream 0x01..0x0A into an empty DEPTH=3 link with ready_i held high.
      for (int t = 0; t < 14; t++) begin
         drive(t < 10, 8'(t + 1), 1, 1, 0, 1);
         chk("stream_valid", 0, int'(vo3), int'(t >= 3 && t <= 12));
         if (t >= 3 && t <= 12) chk("stream_payload", 0, int'(po3), t - 2);
         chk("stream_occ", 0, int'(occ3), imin(t, 10) - imin(imax(t - 3, 0), 10));
      end

      // Backpressure fill: DEPTH=2 absorbs exactly four, then drains in order.
      drive(0, 8'h00, 1, 1, 0, 1);
      drive(0, 8'h00, 1, 1, 0, 1);
      for (int t = 0; t < 8; t++) begin
         drive(1, 8'h11 + 8'(t), 0, 1, 0, 1);
         chk("bp_ready", 1, int'(ro2), int'(t < 4));
         chk("bp_occ", 1, int'(occ2), imin(t, 4));
      end
      chk("bp_occ_d3", 0, int'(occ3), 6);
      chk("bp_occ_d1", 2, int'(occ1), 2);
      chk("bp_hold", 1, int'(po2), 8'h11);
      for (int t = 0; t < 8; t++) begin
         drive(0, 8'h00, 1, 1, 0, 1);
         if (t >= 1 && t <= 3) chk("drain_payload", 1, int'(po2), 8'h11 + t);
      end
      chk("drain_idle_d2", 1, int'(idle2), 1);
      chk("drain_idle_d3", 0, int'(idle3), 1);

      // Flush counting and saturation (DEPTH=1 instance has a 2-bit counter).
      fill(8, 8'h30);
      flush_and_clear();
      chk("flush_valid", 1, int'(vo2), 0);
      chk("flush_occ", 1, int'(occ2), 0);
      chk("flush_drop_d2", 1, int'(drop2), 4);
      chk("flush_drop_d3", 0, int'(drop3), 6);
      chk("flush_drop_d1", 2, int'(drop1), 2);
      flush_and_clear();
      chk("flush_empty_drop", 1, int'(drop2), 4);
      fill(8, 8'h38);
      flush_and_clear();
      chk("sat_drop_d1", 2, int'(drop1), 3);
      fill(8, 8'h40);
      flush_and_clear();
      chk("sat_drop_d1_hold", 2, int'(drop1), 3);
      chk("drop_d3_third", 0, int'(drop3), 18);

      // link_en low: no accepts, held packets still drain.
      fill(4, 8'h50);
      drive(1, 8'h60, 0, 0, 0, 1);
      chk("dis_ready_d1", 2, int'(ro1), 0);
      chk("dis_occ_d1", 2, int'(occ1), 2);
      chk("dis_occ_d2", 1, int'(occ2), 4);
      for (int t = 0; t < 8; t++) drive(1, 8'h61, 1, 0, 0, 1);
      chk("dis_idle_d1", 2, int'(idle1), 1);
      chk("dis_idle_d3", 0, int'(idle3), 1);

      // DEPTH=0 is a gated wire.
      drive(1, 8'hA5, 1, 1, 0, 1);
      chk("bypass_payload", 3, int'(po0), 8'hA5);
      chk("bypass_valid", 3, int'(vo0), 1);
      drive(1, 8'h5A, 1, 0, 0, 1);
      chk("bypass_gated", 3, int'(vo0), 0);
      for (int t = 0; t < 8; t++) drive(0, 8'h00, 1, 1, 0, 1);

      // Reset with three held discards silently and clears the counter.
      fill(3, 8'h70);
      drive(0, 8'h00, 0, 1, 0, 0);
      chk("rst_held_occ", 1, int'(occ2), 3);
      chk("rst_comb_ready", 1, int'(ro2), 0);
      drive(0, 8'h00, 0, 1, 0, 1);
      chk("rst_valid", 1, int'(vo2), 0);
      chk("rst_occ", 1, int'(occ2), 0);
      chk("rst_drop", 1, int'(drop2), 0);
      chk("rst_ready_back", 1, int'(ro2), 1);
      drive(0, 8'h00, 1, 1, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
